// File: rtl/ifetch.sv
// Instruction fetch front end for the synchronous program ROM.
// Keeps the PC, drives the ROM address, tags returned words with their PC and
// buffers them in a small FIFO for decode (valid/ready). Branch redirect flushes
// everything in flight. Optional HALT-opcode stop is enabled by defining the
// macro IFETCH_HALT_EN; without it halted is tied low and fetch never stops.
module ifetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  prom_addr,
  input  logic [INSTR_W-1:0] prom_instruction,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  localparam int unsigned     PTR_W     = $clog2(DEPTH);
  localparam int unsigned     CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  tag_q;
  logic               inflight_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [INSTR_W-1:0] buf_instr_q [DEPTH];
  logic [ADDR_W-1:0]  buf_pc_q    [DEPTH];

  logic               push;
  logic               pop;
  logic               issue;
  logic [CNT_W:0]     occ;

`ifdef IFETCH_HALT_EN
  logic halted_q;
  logic halt_op;

  assign halt_op = (prom_instruction[INSTR_W-1 -: 6] == 6'h3F);
  assign halted  = halted_q;

  // Set on pushing a HALT word; only redirect or reset releases fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= 1'b0;
    end else if (push && halt_op) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

  // Credit check: occupancy after this edge must leave room for a word issued now.
  always_comb begin
    pop     = out_valid & out_ready;
    // While halted, anything still in flight was fetched after the HALT word.
    push    = inflight_q & ~redirect_valid & ~halted;
    occ     = {1'b0, count_q} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
    issue   = ~halted & ~redirect_valid & (occ < DEPTH_OCC);
    count_d = occ[CNT_W-1:0];
  end

  // Head of the buffer and ROM address are pure views of registered state.
  always_comb begin
    prom_addr       = pc_q;
    out_valid       = (count_q != '0);
    out_instruction = buf_instr_q[rd_ptr_q];
    out_pc          = buf_pc_q[rd_ptr_q];
  end

  // PC, in-flight tracking and FIFO bookkeeping; redirect wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_addr;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      inflight_q <= issue;
      count_q    <= count_d;
      if (issue) begin
        pc_q  <= pc_q + ADDR_W'(1);
        tag_q <= pc_q;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Buffer storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= prom_instruction;
      buf_pc_q[wr_ptr_q]    <= tag_q;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by randomized
// ready/redirect traffic, scored against a stream model where decode must see
// consecutive PCs from the last reset/redirect target with word = ROM[pc].
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] prom_addr;
  logic [31:0] prom_instruction;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [15:0] out_pc;
  logic        halted;

  logic [31:0] rom [0:65535];

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  int          zrun   = 0;
  logic [15:0] exp_pc = 16'h0;
  logic        hold   = 1'b0;
  logic [15:0] prev_pc;
  logic [31:0] prev_instr;

  ifetch dut (
    .clk              (clk),
    .rst              (rst),
    .prom_addr        (prom_addr),
    .prom_instruction (prom_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: address sampled at posedge, data valid the next cycle.
  always @(posedge clk) prom_instruction <= rom[prom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Score any pop of this cycle, then advance to just after the next edge.
  task automatic end_cycle();
    if (out_valid && out_ready) begin
      chk("pop_pc", 32'(out_pc), 32'(exp_pc));
      chk("pop_instr", out_instruction, rom[exp_pc]);
      exp_pc = exp_pc + 16'd1;
      pops++;
    end
    if (redirect_valid) exp_pc = redirect_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    end_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(prom_addr), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 16'h0;
    pops = 0;
  endtask

  // Stream from reset, then stall: buffer ends up holding pc 5,6 with pc=7.
  task automatic fill_to_pc7();
    do_reset();
    out_ready = 1'b1;
    repeat (7) cyc();
    out_ready = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = 16'h0;
    for (int i = 0; i < 65536; i++) begin
      rom[i] = $urandom;
      if (rom[i][31:26] == 6'h3F) rom[i][26] = 1'b0;
    end
    #2;

    // 1: streaming from reset at one word per cycle
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t1_addr", 32'(prom_addr), 32'(i));
      chk("t1_valid", 32'(out_valid), 32'(i >= 2));
      if (i >= 2) chk("t1_pc", 32'(out_pc), 32'(i - 2));
      end_cycle();
    end

    // 2: backpressure from reset, then release
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_addr", 32'(prom_addr), 32'((i < 2) ? i : 2));
      chk("t2_valid", 32'(out_valid), 32'(i >= 2));
      if (i >= 2) begin
        chk("t2_pc", 32'(out_pc), 32'd0);
        chk("t2_instr", out_instruction, rom[0]);
      end
      end_cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 2) chk("t2_addr_rel", 32'(prom_addr), 32'(i + 2));
      end_cycle();
    end
    chk("t2_pops", 32'(pops), 32'd6);

    // 3: redirect while buffer holds pc 5,6
    fill_to_pc7();
    redirect_valid = 1'b1;
    redirect_addr = 16'h0040;
    @(negedge clk);
    chk("t3_pre_valid", 32'(out_valid), 32'd1);
    chk("t3_pre_pc", 32'(out_pc), 32'h5);
    end_cycle();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_r1", 32'(out_valid), 32'd0);
    chk("t3_addr_r1", 32'(prom_addr), 32'h40);
    end_cycle();
    @(negedge clk);
    chk("t3_valid_r2", 32'(out_valid), 32'd0);
    chk("t3_addr_r2", 32'(prom_addr), 32'h41);
    end_cycle();
    @(negedge clk);
    chk("t3_valid_r3", 32'(out_valid), 32'd1);
    chk("t3_pc_r3", 32'(out_pc), 32'h40);
    end_cycle();
    repeat (3) cyc();

    // 4: redirect with a same-cycle pop and in-flight word, PC wraps
    redirect_valid = 1'b1;
    redirect_addr = 16'hFFFE;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_valid_gap", 32'(out_valid), 32'd0);
      end_cycle();
    end
    for (int k = 0; k < 4; k++) begin
      logic [15:0] e;
      e = 16'hFFFE + 16'(k);
      @(negedge clk);
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_pc", 32'(out_pc), 32'(e));
      end_cycle();
    end

    // 5: asynchronous reset mid-cycle with buffer full at pc=7
    fill_to_pc7();
    @(negedge clk);
    chk("t5_full_valid", 32'(out_valid), 32'd1);
    chk("t5_pc7", 32'(prom_addr), 32'h7);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_addr", 32'(prom_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = 16'h0;
    pops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_addr", 32'(prom_addr), 32'(i));
      chk("t5_valid", 32'(out_valid), 32'(i >= 2));
      end_cycle();
    end

    // Random ready/redirect traffic against the stream model
    do_reset();
    hold = 1'b0;
    zrun = 0;
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_addr = 16'($urandom);
      @(negedge clk);
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_pc", 32'(out_pc), 32'(prev_pc));
        chk("hold_instr", out_instruction, prev_instr);
      end
      zrun = out_valid ? 0 : zrun + 1;
      chk("starve", 32'(zrun > 2), 32'd0);
      chk("halt_idle", 32'(halted), 32'd0);
      if (redirect_valid) zrun = 0;
      hold = out_valid && !out_ready && !redirect_valid;
      prev_pc = out_pc;
      prev_instr = out_instruction;
      end_cycle();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd1);
    end_cycle();

`ifdef IFETCH_HALT_EN
    // 6: HALT word at ROM[3] stops fetch; redirect resumes it
    do_reset();
    rom[3] = 32'hFC000000;
    out_ready = 1'b1;
    repeat (8) cyc();
    @(negedge clk);
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_pops", 32'(pops), 32'd4);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_addr", 32'(prom_addr), 32'h5);
    redirect_valid = 1'b1;
    redirect_addr = 16'h0010;
    end_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t6_unhalt", 32'(halted), 32'd0);
    chk("t6_addr_r", 32'(prom_addr), 32'h10);
    end_cycle();
    repeat (4) cyc();
    chk("t6_pops_r", 32'(pops), 32'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
